// File: rtl/reg_arbiter.sv
// Two-requester access controller for a shared load-enable register (IDLE/ACCESS/ACK FSM).
// Optional build macro REG_ARBITER_FIXED_PRIO_EN: requester 0 always wins conflicts (no round-robin pointer).
module reg_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] din0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_load,
  input  logic [WIDTH-1:0] reg_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             owner_r;
  logic             we_q_r;
  logic [WIDTH-1:0] din_q_r;
  logic             prio_s;
  logic             grant_s;
  logic             sel_s;

`ifdef REG_ARBITER_FIXED_PRIO_EN
  assign prio_s = 1'b0;
`else
  logic prio_r;

  // Round-robin pointer: the requester that did not just finish wins the next conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= 1'b0;
    end else if (state_r == ST_ACK) begin
      prio_r <= ~owner_r;
    end else begin
      prio_r <= prio_r;
    end
  end

  assign prio_s = prio_r;
`endif

  // Arbitration: a lone requester wins outright, a conflict goes to the pointer.
  always_comb begin
    grant_s = req0 | req1;
    if (req0 && req1) begin
      sel_s = prio_s;
    end else if (req1) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_ACK;
      ST_ACK:    state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction capture; we/din are only sampled in the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= 1'b0;
      we_q_r  <= 1'b0;
      din_q_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_IDLE && grant_s) begin
      owner_r <= sel_s;
      we_q_r  <= sel_s ? we1 : we0;
      din_q_r <= sel_s ? din1 : din0;
    end else begin
      owner_r <= owner_r;
      we_q_r  <= we_q_r;
      din_q_r <= din_q_r;
    end
  end

  // Output decode; reset kills a write in the very cycle it is asserted.
  always_comb begin
    busy     = 1'b0;
    reg_in   = {WIDTH{1'b0}};
    reg_load = 1'b0;
    rdata    = {WIDTH{1'b0}};
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ACCESS: begin
        busy     = 1'b1;
        reg_in   = din_q_r;
        reg_load = we_q_r & ~reset;
      end
      ST_ACK: begin
        busy  = 1'b1;
        rdata = reg_out;
        ack0  = ~owner_r;
        ack1  = owner_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
